fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipeline. Sits directly upstream of the byte-addressed instruction ROM: it owns the program counter, drives the ROM address, and captures the returned 32-bit word into the IF/ID pipeline register consumed by decode. It also handles stall and flush, branch/jump redirect, an end-of-program halt, and a fetch counter.

---
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32I pipeline. Owns the program counter,
// drives the instruction ROM address and captures the returned word into the
// IF/ID pipeline register. Handles stall, flush, branch/jump redirect, an
// end-of-program halt on an all-zero instruction word, and a fetch counter.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target with target_i[1:0] != 0 is refused,
//               the stage halts and the sticky misaligned_o output is raised.
//   undefined : misaligned_o does not exist; target_i[1:0] are forced to 0
//               on redirect.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   stall_i      in   hold PC and IF/ID
//   flush_i      in   squash the word being loaded into IF/ID
//   redirect_i   in   take target_i as next PC
//   target_i     in   redirect target
//   instr_i      in   ROM read data for address pc_o
//   pc_o         out  current PC (ROM address)
//   if_pc_o      out  PC of the word in IF/ID
//   if_pc4_o     out  if_pc_o + 4
//   if_instr_o   out  instruction in IF/ID
//   if_valid_o   out  IF/ID holds a real instruction
//   fetch_cnt_o  out  number of valid words loaded into IF/ID
//   halt_o       out  fetch halted
//   misaligned_o out  sticky misaligned-redirect flag (macro builds only)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP      = 32'h00000013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [31:0]      instr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [WIDTH-1:0] if_pc4_o,
  output logic [31:0]      if_instr_o,
  output logic             if_valid_o,
  output logic [31:0]      fetch_cnt_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic             misaligned_o,
`endif
  output logic             halt_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_pc4_q, if_pc4_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      fetch_cnt_q, fetch_cnt_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_pc;
  logic             target_bad;

  assign pc_plus4 = pc_q + WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  assign redirect_pc  = target_i;
  assign target_bad   = |target_i[1:0];
  assign misaligned_o = misaligned_q;
`else
  // Low address bits are simply dropped: instructions are word aligned.
  assign redirect_pc  = target_i & ~WIDTH'(3);
  assign target_bad   = 1'b0;
`endif

  // Next-state logic. Every branch that squashes IF/ID keeps the old
  // pc/pc4 fields and only replaces the instruction with a NOP bubble.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    fetch_cnt_d = fetch_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif

    if (state_q == RUN) begin
      if (redirect_i) begin
        if_instr_d = NOP;
        if_valid_d = 1'b0;
        if (target_bad) begin
          // Refused redirect: PC holds and the stage parks in HALT.
          state_d = HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
          misaligned_d = 1'b1;
`endif
        end else begin
          pc_d = redirect_pc;
        end
      end else if (flush_i) begin
        if_instr_d = NOP;
        if_valid_d = 1'b0;
        if (!stall_i) begin
          pc_d = pc_plus4;
        end
      end else if (stall_i) begin
        state_d = RUN;
      end else if (instr_i == 32'h0) begin
        // All-zero word marks end of program; it is never counted.
        if_instr_d = NOP;
        if_valid_d = 1'b0;
        state_d    = HALT;
      end else begin
        pc_d        = pc_plus4;
        if_pc_d     = pc_q;
        if_pc4_d    = pc_plus4;
        if_instr_d  = instr_i;
        if_valid_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end else begin
      // HALT ignores stall and flush; only a redirect restarts fetch.
      if_instr_d = NOP;
      if_valid_d = 1'b0;
      if (redirect_i) begin
        if (target_bad) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          misaligned_d = 1'b1;
`endif
          state_d = HALT;
        end else begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
    end
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_pc_q     <= '0;
      if_pc4_q    <= '0;
      if_instr_q  <= NOP;
      if_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign pc_o        = pc_q;
  assign if_pc_o     = if_pc_q;
  assign if_pc4_o    = if_pc4_q;
  assign if_instr_o  = if_instr_q;
  assign if_valid_o  = if_valid_q;
  assign fetch_cnt_o = fetch_cnt_q;
  assign halt_o      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A 64-word ROM model answers pc_o
// combinationally. Each test task pushes the expected post-edge output
// vector to a scoreboard queue before clocking, then pops and compares it.
// Build with +define+FETCH_MISALIGN_TRAP_EN to exercise the trap variant.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    string        name;
    logic [162:0] v;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;
  logic [31:0] fetch_cnt_o;
  logic        halt_o;
  logic        mis_w;

  logic [31:0]  rom [0:63];
  logic [162:0] obs;
  exp_t         sb[$];
  exp_t         e;
  int           total;
  int           bad;

  fetch_stage dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .instr_i     (instr_i),
    .pc_o        (pc_o),
    .if_pc_o     (if_pc_o),
    .if_pc4_o    (if_pc4_o),
    .if_instr_o  (if_instr_o),
    .if_valid_o  (if_valid_o),
    .fetch_cnt_o (fetch_cnt_o),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned_o(mis_w),
`endif
    .halt_o      (halt_o)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign mis_w = 1'b0;
`endif

  assign instr_i = rom[pc_o[7:2]];
  assign obs = {pc_o, if_pc_o, if_pc4_o, if_instr_o, if_valid_o, fetch_cnt_o, halt_o, mis_w};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input string n, input logic [31:0] pc, input logic [31:0] ip,
                              input logic [31:0] ip4, input logic [31:0] ins, input logic v,
                              input logic [31:0] c, input logic h, input logic m);
    exp_t r;
    r.name = n;
    r.v    = {pc, ip, ip4, ins, v, c, h, m};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst_i      = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    redirect_i = 1'b0;
    target_i   = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    sb.push_back(mk("reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 1'b0, 1'b0));
    tick();
    rst_i = 1'b0;
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(mk("seq", 32'(4*i), 32'(4*(i-1)), 32'(4*i), rom[i-1], 1'b1, 32'(i), 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e.v) begin bad++; $display("[TB] FAIL %s%0d: got %h want %h", e.name, i, obs, e.v); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk("stall_hold", 32'h8, 32'h4, 32'h8, rom[1], 1'b1, 32'd2, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    end
    stall_i = 1'b0;
    sb.push_back(mk("stall_resume", 32'hC, 32'h8, 32'hC, rom[2], 1'b1, 32'd3, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect_i = 1'b1;
    target_i   = 32'h40;
    sb.push_back(mk("redir_bubble", 32'h40, 32'hC, 32'h10, NOP, 1'b0, 32'd4, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("redir_load", 32'h44, 32'h40, 32'h44, rom[16], 1'b1, 32'd5, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_back_to_back();
    // redirect + stall + flush together, then flush with stall, then flush alone
    do_reset();
    tick();
    redirect_i = 1'b1;
    stall_i    = 1'b1;
    flush_i    = 1'b1;
    target_i   = 32'h80;
    sb.push_back(mk("all_three", 32'h80, 32'h0, 32'h4, NOP, 1'b0, 32'd1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("after_all_three", 32'h84, 32'h80, 32'h84, rom[32], 1'b1, 32'd2, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    flush_i = 1'b1;
    stall_i = 1'b1;
    sb.push_back(mk("flush_stall", 32'h84, 32'h80, 32'h84, NOP, 1'b0, 32'd2, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    stall_i = 1'b0;
    sb.push_back(mk("flush_only", 32'h88, 32'h80, 32'h84, NOP, 1'b0, 32'd2, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1'b1;
    target_i   = 32'hFFFFFFFC;
    sb.push_back(mk("wrap_redir", 32'hFFFFFFFC, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("wrap_pc4", 32'h0, 32'hFFFFFFFC, 32'h0, rom[63], 1'b1, 32'd1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    saved  = rom[8];
    rom[8] = 32'h0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      sb.push_back(mk("pre_halt", 32'(4*i), 32'(4*(i-1)), 32'(4*i), rom[i-1], 1'b1, 32'(i), 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e.v) begin bad++; $display("[TB] FAIL %s%0d: got %h want %h", e.name, i, obs, e.v); end
    end
    for (int i = 0; i < 5; i++) begin
      stall_i = (i == 2);
      flush_i = (i == 3);
      sb.push_back(mk("halted", 32'h20, 32'h1C, 32'h20, NOP, 1'b0, 32'd8, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e.v) begin bad++; $display("[TB] FAIL %s%0d: got %h want %h", e.name, i, obs, e.v); end
    end
    clear_inputs();
    redirect_i = 1'b1;
    target_i   = 32'h0;
    sb.push_back(mk("halt_exit", 32'h0, 32'h1C, 32'h20, NOP, 1'b0, 32'd8, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("halt_restart", 32'h4, 32'h0, 32'h4, rom[0], 1'b1, 32'd9, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    redirect_i = 1'b1;
    target_i   = 32'h20;
    tick();
    clear_inputs();
    sb.push_back(mk("halt_again", 32'h20, 32'h0, 32'h4, NOP, 1'b0, 32'd9, 1'b1, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    rst_i      = 1'b1;
    redirect_i = 1'b1;
    target_i   = 32'h40;
    sb.push_back(mk("reset_in_halt", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    rom[8] = saved;
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    redirect_i = 1'b1;
    target_i   = 32'h42;
`ifdef FETCH_MISALIGN_TRAP_EN
    sb.push_back(mk("misalign_trap", 32'h4, 32'h0, 32'h4, NOP, 1'b0, 32'd1, 1'b1, 1'b1));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    target_i = 32'h40;
    sb.push_back(mk("misalign_exit", 32'h40, 32'h0, 32'h4, NOP, 1'b0, 32'd1, 1'b0, 1'b1));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("misalign_sticky", 32'h44, 32'h40, 32'h44, rom[16], 1'b1, 32'd2, 1'b0, 1'b1));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    rst_i = 1'b1;
    sb.push_back(mk("misalign_reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
`else
    sb.push_back(mk("misalign_forced", 32'h40, 32'h0, 32'h4, NOP, 1'b0, 32'd1, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    clear_inputs();
    sb.push_back(mk("misalign_load", 32'h44, 32'h40, 32'h44, rom[16], 1'b1, 32'd2, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    total++;
    if (obs !== e.v) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
`endif
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) rom[i] = {12'(i + 1), 20'h00013};
    rom[0] = 32'h00500093;
    rom[1] = 32'h00100113;
    rom[2] = 32'h002081B3;
    clear_inputs();
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_misalign();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
